// File: rtl/regfile_wb_queue.sv
// Write-back queue for the 32x64 register file: buffers ALU/load results, drains one per cycle,
// and tracks per-register pending writes for decode stalls. Define WB_FWD_EN for FWD1/FWD2 ports.
module regfile_wb_queue #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4,
    parameter int NREG  = 32
) (
    input  logic                     CLK,
    input  logic                     reset_n,
    input  logic                     ALU_V,
    input  logic [4:0]               ALU_DR,
    input  logic [XLEN-1:0]          ALU_DATA,
    output logic                     ALU_RDY,
    input  logic                     MEM_V,
    input  logic [4:0]               MEM_DR,
    input  logic [XLEN-1:0]          MEM_DATA,
    output logic                     MEM_RDY,
    input  logic                     ISSUE_V,
    input  logic [4:0]               ISSUE_DR,
    input  logic [4:0]               SR1,
    input  logic [4:0]               SR2,
    output logic                     STALL,
    output logic [4:0]               DR,
    output logic [XLEN-1:0]          WB_DATA,
    output logic                     ST_REG,
    output logic [$clog2(DEPTH):0]   COUNT
`ifdef WB_FWD_EN
    ,
    output logic                     FWD1_V,
    output logic                     FWD2_V,
    output logic [XLEN-1:0]          FWD1_DATA,
    output logic [XLEN-1:0]          FWD2_DATA
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]      fifo_dr_q   [DEPTH];
    logic [4:0]      fifo_dr_d   [DEPTH];
    logic [XLEN-1:0] fifo_data_q [DEPTH];
    logic [XLEN-1:0] fifo_data_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [NREG-1:0] pending_q, pending_d;
    logic            st_reg_q, st_reg_d;
    logic [4:0]      dr_q, dr_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;

    logic [CW-1:0]   free;
    logic [PW-1:0]   alu_slot;
    logic            mem_store, alu_store, pop;
    logic            fwd1, fwd2;

    always_comb begin
        free      = CW'(DEPTH) - count_q;
        MEM_RDY   = (free >= CW'(1));
        ALU_RDY   = MEM_V ? (free >= CW'(2)) : (free >= CW'(1));
        mem_store = MEM_V & MEM_RDY & (MEM_DR != '0);
        alu_store = ALU_V & ALU_RDY & (ALU_DR != '0);
        pop       = (count_q != '0) | mem_store | alu_store;
        alu_slot  = wr_ptr_q + PW'(mem_store);

        fifo_dr_d   = fifo_dr_q;
        fifo_data_d = fifo_data_q;
        if (mem_store) begin
            fifo_dr_d[wr_ptr_q]   = MEM_DR;
            fifo_data_d[wr_ptr_q] = MEM_DATA;
        end
        if (alu_store) begin
            fifo_dr_d[alu_slot]   = ALU_DR;
            fifo_data_d[alu_slot] = ALU_DATA;
        end
        wr_ptr_d = wr_ptr_q + PW'(mem_store) + PW'(alu_store);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(mem_store) + CW'(alu_store) - CW'(pop);

        // Head is read from the post-write array: when empty, rd_ptr==wr_ptr, so the
        // first incoming result bypasses straight to the write port in the same edge.
        st_reg_d  = pop;
        dr_d      = dr_q;
        wb_data_d = wb_data_q;
        if (pop) begin
            dr_d      = fifo_dr_d[rd_ptr_q];
            wb_data_d = fifo_data_d[rd_ptr_q];
        end

        pending_d = pending_q;
        if (st_reg_q) pending_d[dr_q] = 1'b0;
        if (ISSUE_V && (ISSUE_DR != '0)) pending_d[ISSUE_DR] = 1'b1;
        pending_d[0] = 1'b0;

`ifdef WB_FWD_EN
        fwd1 = st_reg_q & (SR1 == dr_q) & (SR1 != '0);
        fwd2 = st_reg_q & (SR2 == dr_q) & (SR2 != '0);
`else
        fwd1 = 1'b0;
        fwd2 = 1'b0;
`endif
        STALL = ((SR1 != '0) & pending_q[SR1] & ~fwd1) |
                ((SR2 != '0) & pending_q[SR2] & ~fwd2);
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_dr_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pending_q <= '0;
            st_reg_q  <= 1'b0;
            dr_q      <= '0;
            wb_data_q <= '0;
        end else begin
            fifo_dr_q   <= fifo_dr_d;
            fifo_data_q <= fifo_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pending_q   <= pending_d;
            st_reg_q    <= st_reg_d;
            dr_q        <= dr_d;
            wb_data_q   <= wb_data_d;
        end
    end

    assign DR      = dr_q;
    assign WB_DATA = wb_data_q;
    assign ST_REG  = st_reg_q;
    assign COUNT   = count_q;

`ifdef WB_FWD_EN
    assign FWD1_V    = fwd1;
    assign FWD2_V    = fwd2;
    assign FWD1_DATA = wb_data_q;
    assign FWD2_DATA = wb_data_q;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Randomized self-checking bench for regfile_wb_queue against a queue-based reference model.
module tb_regfile_wb_queue;
    localparam int XLEN  = 64;
    localparam int DEPTH = 4;
    localparam int NREG  = 32;

    logic            CLK = 1'b0;
    logic            reset_n = 1'b0;
    logic            ALU_V = 1'b0, MEM_V = 1'b0, ISSUE_V = 1'b0;
    logic [4:0]      ALU_DR = '0, MEM_DR = '0, ISSUE_DR = '0, SR1 = '0, SR2 = '0;
    logic [XLEN-1:0] ALU_DATA = '0, MEM_DATA = '0;
    logic            ALU_RDY, MEM_RDY, STALL, ST_REG;
    logic [4:0]      DR;
    logic [XLEN-1:0] WB_DATA;
    logic [$clog2(DEPTH):0] COUNT;
`ifdef WB_FWD_EN
    logic            FWD1_V, FWD2_V;
    logic [XLEN-1:0] FWD1_DATA, FWD2_DATA;
`endif

    always #5 CLK = ~CLK;

    regfile_wb_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .NREG(NREG)) dut (
        .CLK(CLK), .reset_n(reset_n),
        .ALU_V(ALU_V), .ALU_DR(ALU_DR), .ALU_DATA(ALU_DATA), .ALU_RDY(ALU_RDY),
        .MEM_V(MEM_V), .MEM_DR(MEM_DR), .MEM_DATA(MEM_DATA), .MEM_RDY(MEM_RDY),
        .ISSUE_V(ISSUE_V), .ISSUE_DR(ISSUE_DR), .SR1(SR1), .SR2(SR2), .STALL(STALL),
        .DR(DR), .WB_DATA(WB_DATA), .ST_REG(ST_REG), .COUNT(COUNT)
`ifdef WB_FWD_EN
        , .FWD1_V(FWD1_V), .FWD2_V(FWD2_V), .FWD1_DATA(FWD1_DATA), .FWD2_DATA(FWD2_DATA)
`endif
    );

    typedef struct packed {
        logic [4:0]      dr;
        logic [XLEN-1:0] data;
    } ent_t;

    // Reference model: results in arrival order, one retired per edge.
    ent_t            q[$];
    bit              pend[NREG];
    bit              e_st;
    logic [4:0]      e_dr;
    logic [XLEN-1:0] e_data;
    int              vectors = 0;
    int              errors  = 0;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        foreach (pend[i]) pend[i] = 1'b0;
        e_st = 1'b0; e_dr = '0; e_data = '0;
    endtask

    function automatic int free_slots();
        return DEPTH - q.size();
    endfunction

    function automatic bit m_mem_rdy();
        return free_slots() >= 1;
    endfunction

    function automatic bit m_alu_rdy();
        return free_slots() >= 1 + (MEM_V ? 1 : 0);
    endfunction

    function automatic bit m_fwd(input logic [4:0] s);
`ifdef WB_FWD_EN
        return e_st && (s == e_dr) && (s != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_stall();
        bit s1, s2;
        s1 = (SR1 != 0) && pend[SR1] && !m_fwd(SR1);
        s2 = (SR2 != 0) && pend[SR2] && !m_fwd(SR2);
        return s1 || s2;
    endfunction

    task automatic model_edge();
        bit mr, ar;
        ent_t h;
        mr = m_mem_rdy();
        ar = m_alu_rdy();
        if (e_st) pend[e_dr] = 1'b0;
        if (ISSUE_V && ISSUE_DR != 0) pend[ISSUE_DR] = 1'b1;
        if (MEM_V && mr && MEM_DR != 0) q.push_back('{dr: MEM_DR, data: MEM_DATA});
        if (ALU_V && ar && ALU_DR != 0) q.push_back('{dr: ALU_DR, data: ALU_DATA});
        if (q.size() > 0) begin
            h = q.pop_front();
            e_st = 1'b1; e_dr = h.dr; e_data = h.data;
        end else begin
            e_st = 1'b0;
        end
    endtask

    task automatic check_comb();
        chk("mem_rdy", MEM_RDY, m_mem_rdy());
        chk("alu_rdy", ALU_RDY, m_alu_rdy());
        chk("stall", STALL, m_stall());
        chk("count", COUNT, q.size());
`ifdef WB_FWD_EN
        chk("fwd1_v", FWD1_V, m_fwd(SR1));
        chk("fwd2_v", FWD2_V, m_fwd(SR2));
        chk("fwd1_data", FWD1_DATA, e_data);
        chk("fwd2_data", FWD2_DATA, e_data);
`endif
    endtask

    task automatic check_reg();
        chk("st_reg", ST_REG, e_st);
        chk("dr", DR, e_dr);
        chk("wb_data", WB_DATA, e_data);
        chk("count_post", COUNT, q.size());
    endtask

    // Called in the low phase with inputs already driven; returns at the next negedge.
    task automatic cycle();
        #1 check_comb();
        @(posedge CLK);
        model_edge();
        #1 check_reg();
        @(negedge CLK);
    endtask

    task automatic idle();
        ALU_V = 0; MEM_V = 0; ISSUE_V = 0;
        ALU_DR = '0; MEM_DR = '0; ISSUE_DR = '0;
        ALU_DATA = '0; MEM_DATA = '0;
    endtask

    // Asserts reset mid low-phase and checks the immediate effect; caller releases it.
    task automatic mid_reset();
        #2 reset_n = 1'b0;
        model_clear();
        #1 check_comb();
        check_reg();
    endtask

    initial begin
        idle();
        model_clear();
        repeat (2) @(negedge CLK);
        reset_n = 1'b1;
        #1;
        chk("rst_st_reg", ST_REG, 1'b0);
        chk("rst_dr", DR, 5'd0);
        chk("rst_wb_data", WB_DATA, '0);
        chk("rst_count", COUNT, 0);
        @(negedge CLK);

        // x0 results are accepted but dropped; issuing to x0 never stalls
        ALU_V = 1; ALU_DR = 5'd0; ALU_DATA = 64'hFFFF;
        ISSUE_V = 1; ISSUE_DR = 5'd0;
        #1 chk("x0_alu_rdy", ALU_RDY, 1'b1);
        cycle();
        chk("x0_count", COUNT, 0);
        chk("x0_st_reg", ST_REG, 1'b0);
        idle();
        #1 chk("x0_stall", STALL, 1'b0);
        cycle();

        // single ALU result, one-cycle latency, scoreboard stall release
        ISSUE_V = 1; ISSUE_DR = 5'd5;
        ALU_V = 1; ALU_DR = 5'd5; ALU_DATA = 64'hA5;
        SR1 = 5'd5;
        cycle();
        chk("lat_st_reg", ST_REG, 1'b1);
        chk("lat_dr", DR, 5'd5);
        chk("lat_wb_data", WB_DATA, 64'hA5);
        idle();
        SR2 = 5'd5;
`ifdef WB_FWD_EN
        #1 chk("fwd_stall", STALL, 1'b0);
        chk("fwd2_v_lit", FWD2_V, 1'b1);
        chk("fwd2_data_lit", FWD2_DATA, 64'hA5);
`else
        #1 chk("wb_cycle_stall", STALL, 1'b1);
`endif
        cycle();
        #1 chk("stall_cleared", STALL, 1'b0);
        cycle();
        SR1 = '0; SR2 = '0;

        // MEM before ALU in the same cycle
        MEM_V = 1; MEM_DR = 5'd3; MEM_DATA = 64'h33;
        ALU_V = 1; ALU_DR = 5'd4; ALU_DATA = 64'h44;
        #1 chk("both_mem_rdy", MEM_RDY, 1'b1);
        chk("both_alu_rdy", ALU_RDY, 1'b1);
        cycle();
        chk("order_dr0", DR, 5'd3);
        chk("order_cnt", COUNT, 1);
        idle();
        cycle();
        chk("order_dr1", DR, 5'd4);
        chk("order_data1", WB_DATA, 64'h44);
        cycle();

        // fill while draining, then reset mid-drain with entries queued
        for (int i = 0; i < 3; i++) begin
            MEM_V = 1; MEM_DR = 5'(10 + i); MEM_DATA = 64'(100 + i);
            ALU_V = 1; ALU_DR = 5'(20 + i); ALU_DATA = 64'(200 + i);
            ISSUE_V = (i == 0); ISSUE_DR = 5'd9;
            cycle();
        end
        chk("fill_count", COUNT, 3);
        ISSUE_V = 0;
        SR1 = 5'd9;
        #1 chk("fill_alu_rdy", ALU_RDY, 1'b0);
        chk("fill_mem_rdy", MEM_RDY, 1'b1);
        chk("fill_stall", STALL, 1'b1);
        mid_reset();
        chk("mrst_st_reg", ST_REG, 1'b0);
        chk("mrst_count", COUNT, 0);
        chk("mrst_stall", STALL, 1'b0);
        idle();
        @(negedge CLK);
        reset_n = 1'b1;
        repeat (3) cycle();
        chk("mrst_no_write", ST_REG, 1'b0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] idr;
            MEM_V = 1'($urandom_range(0, 1));
            MEM_DR = 5'($urandom_range(0, 7));
            MEM_DATA = {$urandom, $urandom};
            ALU_V = 1'($urandom_range(0, 1));
            ALU_DR = 5'($urandom_range(0, 7));
            ALU_DATA = {$urandom, $urandom};
            idr = 5'($urandom_range(0, 7));
            ISSUE_DR = idr;
            ISSUE_V = ($urandom_range(0, 2) == 0) && (!pend[idr] || (e_st && e_dr == idr));
            SR1 = 5'($urandom_range(0, 7));
            SR2 = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 299) == 0) begin
                mid_reset();
                @(negedge CLK);
                reset_n = 1'b1;
            end else begin
                cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
